alu_op_sequencer: RTL

Command-driven controller that sequences the lab's 4-bit ALU over multiple cycles. It accepts an operation command over a valid/ready handshake and drives the ALU's a/b/Cin/opcode inputs from registers. Each iteration it captures f/Cout/fEq0/aGTb and feeds f[3:0] and Cout back as the next a and Cin, for a programmable repeat count. It sits between the switch/button front end (or a test driver) and the combinational ALU instance, and returns the final result over a second handshake.

---
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle command sequencer around the 4-bit ALU (optional abort: ALU_SEQ_ABORT_EN)
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_cin,
    input  logic       cmd_load,
    input  logic [3:0] cmd_count,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_f,
    input  logic       alu_cout,
    input  logic       alu_feq0,
    input  logic       alu_agtb,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_f,
    output logic       res_cout,
    output logic       res_zero,
    output logic       res_agtb,
`ifdef ALU_SEQ_ABORT_EN
    input  logic       abort,
    output logic       res_aborted,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Settle counter counts down to zero; the capture happens on the edge where it is zero.
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] acc;
    logic       carry;
    logic [3:0] op_reg;
    logic [3:0] b_reg;
    logic [4:0] remaining;
    logic [3:0] settle;
    logic       accept;
    logic       capture;
    logic       abort_req;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ALU inputs come straight from registers so the ALU never sees cmd_* glitches.
    assign alu_a      = acc;
    assign alu_b      = b_reg;
    assign alu_cin    = carry;
    assign alu_opcode = op_reg;

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (abort_req) begin
                    state_d = DONE;
                end else if (settle == 4'd0) begin
                    capture = 1'b1;
                    if (remaining == 5'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, iteration bookkeeping, result capture and accumulator feedback.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= 4'd0;
            carry     <= 1'b0;
            op_reg    <= 4'd0;
            b_reg     <= 4'd0;
            remaining <= 5'd0;
            settle    <= 4'd0;
            res_f     <= 8'd0;
            res_cout  <= 1'b0;
            res_zero  <= 1'b0;
            res_agtb  <= 1'b0;
        end else if (accept) begin
            op_reg    <= cmd_opcode;
            b_reg     <= cmd_b;
            remaining <= (cmd_count == 4'd0) ? 5'd16 : {1'b0, cmd_count};
            settle    <= SETTLE_RELOAD;
            if (cmd_load) begin
                acc   <= cmd_a;
                carry <= cmd_cin;
            end
        end else if (state_q == EXEC && !abort_req) begin
            if (capture) begin
                res_f     <= alu_f;
                res_cout  <= alu_cout;
                res_zero  <= alu_feq0;
                res_agtb  <= alu_agtb;
                acc       <= alu_f[3:0];
                carry     <= alu_cout;
                remaining <= remaining - 5'd1;
                settle    <= SETTLE_RELOAD;
            end else begin
                settle <= settle - 4'd1;
            end
        end
    end

`ifdef ALU_SEQ_ABORT_EN
    // Abort flag: set when an abort ends EXEC, cleared by the next accepted command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_aborted <= 1'b0;
        end else if (accept) begin
            res_aborted <= 1'b0;
        end else if (state_q == EXEC && abort_req) begin
            res_aborted <= 1'b1;
        end
    end
`endif

endmodule
